// File: rtl/ram_block_copier_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_block_copier_if
// Brief    : Control and memory-bus bundle for ram_block_copier.
//            master = copier side, slave = core + ram side.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_block_copier_if #(
  parameter int DATA_LEN    = 16,
  parameter int ADDRESS_LEN = 8
);
  logic                     start;
  logic [ADDRESS_LEN-1:0]   src_addr;
  logic [ADDRESS_LEN-1:0]   dst_addr;
  logic [ADDRESS_LEN:0]     length;
  logic                     fill;
  logic [DATA_LEN-1:0]      fill_value;
  logic                     busy;
  logic                     done;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDRESS_LEN*3-1:0] mem_address;
  logic [DATA_LEN*3-1:0]    mem_wdata;
  logic [DATA_LEN*3-1:0]    mem_rdata;

  modport master (
    input  start, src_addr, dst_addr, length, fill, fill_value, mem_rdata,
    output busy, done, mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    output start, src_addr, dst_addr, length, fill, fill_value, mem_rdata,
    input  busy, done, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/ram_block_copier.sv
`default_nettype none
// ============================================================================
// Module   : ram_block_copier
// Brief    : Block copy engine for the triple-port ram. Moves three words per
//            transaction (one READ cycle, one WRITE cycle). Optional fill mode
//            (write-only, one cycle per triple) is built when the macro
//            RAM_BLOCK_COPIER_FILL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ram_block_copier #(
  parameter int DATA_LEN    = 16,
  parameter int ADDRESS_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  ram_block_copier_if.master bus
);

  localparam int                     LANES       = 3;
  localparam logic [ADDRESS_LEN-1:0] C_PTR_STEP  = ADDRESS_LEN'(LANES);
  localparam logic [ADDRESS_LEN:0]   C_LANES_CNT = (ADDRESS_LEN+1)'(LANES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
`ifdef RAM_BLOCK_COPIER_FILL_EN
    S_FWRITE = 3'd4,
`endif
    S_FINISH = 3'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDRESS_LEN-1:0]   r_src_ptr;
  logic [ADDRESS_LEN-1:0]   r_dst_ptr;
  logic [ADDRESS_LEN:0]     r_remaining;
  logic [ADDRESS_LEN:0]     w_remaining_next;
  logic [LANES-1:0]         w_lane_valid;
  logic [LANES*ADDRESS_LEN-1:0] w_src_lanes;
  logic [LANES*ADDRESS_LEN-1:0] w_dst_lanes;
  logic [LANES*DATA_LEN-1:0]    w_copy_data;

`ifdef RAM_BLOCK_COPIER_FILL_EN
  logic                     r_fill;
  logic [DATA_LEN-1:0]      r_fill_value;
`else
  // Fill inputs have no function in a copy-only build.
  logic                     w_unused_fill_inputs;
  assign w_unused_fill_inputs = ^{bus.fill, bus.fill_value};
`endif

  // Words left after the current triple; never underflows on a short tail.
  assign w_remaining_next = (r_remaining > C_LANES_CNT) ? (r_remaining - C_LANES_CNT) : '0;

  // Per-lane addressing; lanes past the block tail alias lane 0 so nothing
  // outside the block is touched and the duplicate write is idempotent.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_lane_valid[i] = (r_remaining > (ADDRESS_LEN+1)'(i));
    assign w_src_lanes[i*ADDRESS_LEN +: ADDRESS_LEN] =
      w_lane_valid[i] ? (r_src_ptr + ADDRESS_LEN'(i)) : r_src_ptr;
    assign w_dst_lanes[i*ADDRESS_LEN +: ADDRESS_LEN] =
      w_lane_valid[i] ? (r_dst_ptr + ADDRESS_LEN'(i)) : r_dst_ptr;
    assign w_copy_data[i*DATA_LEN +: DATA_LEN] =
      w_lane_valid[i] ? bus.mem_rdata[i*DATA_LEN +: DATA_LEN] : bus.mem_rdata[DATA_LEN-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            w_next_state = S_FINISH;
          end else begin
`ifdef RAM_BLOCK_COPIER_FILL_EN
            if (bus.fill) w_next_state = S_FWRITE;
            else          w_next_state = S_READ;
`else
            w_next_state = S_READ;
`endif
          end
        end
      end
      S_READ:   w_next_state = S_WRITE;
      S_WRITE:  w_next_state = (w_remaining_next != '0) ? S_READ : S_FINISH;
`ifdef RAM_BLOCK_COPIER_FILL_EN
      S_FWRITE: w_next_state = (w_remaining_next != '0) ? S_FWRITE : S_FINISH;
`endif
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Request latch and pointer/counter advance after each write transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_remaining  <= '0;
`ifdef RAM_BLOCK_COPIER_FILL_EN
      r_fill       <= 1'b0;
      r_fill_value <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_src_ptr    <= bus.src_addr;
            r_dst_ptr    <= bus.dst_addr;
            r_remaining  <= bus.length;
`ifdef RAM_BLOCK_COPIER_FILL_EN
            r_fill       <= bus.fill;
            r_fill_value <= bus.fill_value;
`endif
          end
        end
        S_WRITE: begin
          r_src_ptr   <= r_src_ptr + C_PTR_STEP;
          r_dst_ptr   <= r_dst_ptr + C_PTR_STEP;
          r_remaining <= w_remaining_next;
        end
`ifdef RAM_BLOCK_COPIER_FILL_EN
        S_FWRITE: begin
          r_dst_ptr   <= r_dst_ptr + C_PTR_STEP;
          r_remaining <= w_remaining_next;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from registered state; read data reaches mem_wdata only in WRITE.
  always_comb begin
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    case (r_state)
      S_READ: begin
        bus.busy        = 1'b1;
        bus.mem_read    = 1'b1;
        bus.mem_address = w_src_lanes;
      end
      S_WRITE: begin
        bus.busy        = 1'b1;
        bus.mem_write   = 1'b1;
        bus.mem_address = w_dst_lanes;
        bus.mem_wdata   = w_copy_data;
      end
`ifdef RAM_BLOCK_COPIER_FILL_EN
      S_FWRITE: begin
        bus.busy        = 1'b1;
        bus.mem_write   = 1'b1;
        bus.mem_address = w_dst_lanes;
        bus.mem_wdata   = {LANES{r_fill_value}};
      end
`endif
      S_FINISH: bus.done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_block_copier.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_block_copier
// Brief    : Self-checking bench for ram_block_copier with a behavioural ram
//            and a triple-order copy/fill reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_block_copier;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] ram     [256];
  logic [15:0] ref_mem [256];
  logic        do_sync = 1'b0;

  ram_block_copier_if #(.DATA_LEN(16), .ADDRESS_LEN(8)) bus ();

  ram_block_copier #(.DATA_LEN(16), .ADDRESS_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Triple-port ram with one-cycle read latency; do_sync reloads it from the model.
  always @(posedge clk) begin
    if (do_sync) begin
      for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
    end else begin
      if (bus.mem_read)
        bus.mem_rdata <= {ram[bus.mem_address[23:16]], ram[bus.mem_address[15:8]], ram[bus.mem_address[7:0]]};
      if (bus.mem_write)
        for (int j = 0; j < 3; j++) ram[bus.mem_address[j*8 +: 8]] <= bus.mem_wdata[j*16 +: 16];
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync_ram();
    @(negedge clk);
    do_sync = 1'b1;
    @(negedge clk);
    do_sync = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                        input logic fl, input logic [15:0] fv, input int rst_at, input logic poke_busy);
    int busy_cnt = 0, done_cnt = 0, done_at = 0, rd_cnt = 0, wr_cnt = 0, clash = 0;
    int t, lim, exp_busy, exp_rd, rem, n, mism;
    logic honour_fill;
    logic [23:0] first_rd = '0, last_wr = '0, exp_first_rd = '0, exp_last_wr = '0;
    logic [7:0]  s, d;
    logic [7:0]  a_s [3];
    logic [7:0]  a_d [3];
    logic [15:0] tmp [3];
`ifdef RAM_BLOCK_COPIER_FILL_EN
    honour_fill = fl;
`else
    honour_fill = 1'b0;
`endif
    t = (int'(len) + 2) / 3;

    @(negedge clk);
    bus.src_addr = src; bus.dst_addr = dst; bus.length = len;
    bus.fill = fl; bus.fill_value = fv; bus.start = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.mem_read && bus.mem_write) clash++;
      if (bus.mem_read) begin
        rd_cnt++;
        if (rd_cnt == 1) first_rd = bus.mem_address;
      end
      if (bus.mem_write) begin
        wr_cnt++;
        last_wr = bus.mem_address;
      end
      if (poke_busy && c == 2) begin
        bus.src_addr = src + 8'd40; bus.dst_addr = dst + 8'd80; bus.start = 1'b1;
      end
      if (poke_busy && c == 3) bus.start = 1'b0;
      if (bus.done && done_at == 0) begin
        done_at = c;
        bus.start = 1'b1;
      end
      if (done_at != 0 && c == done_at + 1) bus.start = 1'b0;
      if (rst_at != 0 && c == rst_at) begin
        reset = 1'b1;
        #1;
        check("reset_outputs_zero",
              {bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata}, '0);
      end
      if (rst_at != 0 && c == rst_at + 2) reset = 1'b0;
      if (rst_at != 0 && c == rst_at + 4) break;
      if (rst_at == 0 && done_at != 0 && c == done_at + 3) break;
    end

    // Reference: whole triples in order, each reading its source words then writing them.
    if (rst_at == 0)      lim = t;
    else if (honour_fill) lim = rst_at - 1;
    else                  lim = (rst_at - 1) / 2;
    s = src; d = dst; rem = int'(len);
    for (int k = 0; k < lim; k++) begin
      n = (rem < 3) ? rem : 3;
      for (int j = 0; j < 3; j++) begin
        a_s[j] = (j < n) ? s + 8'(j) : s;
        a_d[j] = (j < n) ? d + 8'(j) : d;
      end
      if (k == 0) exp_first_rd = {a_s[2], a_s[1], a_s[0]};
      exp_last_wr = {a_d[2], a_d[1], a_d[0]};
      if (honour_fill) begin
        for (int j = 0; j < n; j++) ref_mem[a_d[j]] = fv;
      end else begin
        for (int j = 0; j < n; j++) tmp[j] = ref_mem[a_s[j]];
        for (int j = 0; j < n; j++) ref_mem[a_d[j]] = tmp[j];
      end
      s = s + 8'd3; d = d + 8'd3; rem = rem - n;
    end

    exp_busy = honour_fill ? t : 2 * t;
    exp_rd   = honour_fill ? 0 : t;
    if (rst_at == 0) begin
      check("busy_cycles", busy_cnt, exp_busy);
      check("done_pulses", done_cnt, 1);
      check("done_cycle", done_at, exp_busy + 1);
      check("read_count", rd_cnt, exp_rd);
      check("write_count", wr_cnt, t);
      if (len != 0) check("last_write_lanes", last_wr, exp_last_wr);
    end else begin
      check("no_done_after_reset", done_cnt, 0);
      check("writes_before_reset", wr_cnt, lim);
    end
    check("read_write_clash", clash, 0);
    if (len != 0 && !honour_fill) check("first_read_lanes", first_rd, exp_first_rd);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("memory_image", mism, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    bus.fill = 1'b0; bus.fill_value = '0;
    #1;
    check("reset_state", {bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
    ref_mem[62] = 16'd10; ref_mem[63] = 16'd2; ref_mem[64] = 16'd1;
    ref_mem[65] = 16'd2;  ref_mem[66] = 16'd3; ref_mem[67] = 16'd4;
    for (int i = 114; i < 120; i++) ref_mem[i] = 16'd0;
    sync_ram();

    // Full triples.
    run_op(8'd62, 8'd114, 9'd6, 1'b0, 16'h0, 0, 1'b0);
    check("copy6_mem114", ram[114], 16'd10);
    check("copy6_mem119", ram[119], 16'd4);

    // Short tail.
    for (int i = 114; i < 120; i++) ref_mem[i] = 16'd0;
    sync_ram();
    run_op(8'd62, 8'd114, 9'd4, 1'b0, 16'h0, 0, 1'b0);
    check("tail_mem117", ram[117], 16'd2);
    check("tail_mem118_untouched", ram[118], 16'd0);

    // Zero length.
    run_op(8'd30, 8'd70, 9'd0, 1'b0, 16'h0, 0, 1'b0);

    // Address wrap, with a start pulse while busy.
    run_op(8'd254, 8'd10, 9'd3, 1'b0, 16'h0, 0, 1'b1);

    // Reset in the third busy cycle of a nine-word copy.
    run_op(8'd20, 8'd150, 9'd9, 1'b0, 16'h0, 3, 1'b0);

    // Fill request.
    run_op(8'd0, 8'd100, 9'd5, 1'b1, 16'hABCD, 0, 1'b0);
`ifdef RAM_BLOCK_COPIER_FILL_EN
    check("fill_mem100", ram[100], 16'hABCD);
    check("fill_mem104", ram[104], 16'hABCD);
`endif

    // Maximum length.
    run_op(8'd5, 8'd9, 9'd256, 1'b0, 16'h0, 0, 1'b0);

    // Randomized requests.
    for (int r = 0; r < 10; r++)
      run_op(8'($urandom), 8'($urandom), 9'($urandom_range(0, 30)), 1'($urandom_range(0, 1)),
             16'($urandom), 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
